// File: rtl/spectol_writer.sv
// Start_SW/Busy_SW responder that writes one spectrum bin per request into the display RAM.
// Optional decaying peak-hold merge with the stored bin is enabled by defining PEAK_HOLD_EN.
module spectol_writer #(
  parameter int bw_spec  = 8,
  parameter int bw_bin   = 7,
  parameter int NUM_BINS = 128,
  parameter int DECAY    = 1
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               obstart,
  input  logic               Start_SW,
  input  logic               Copy,
  input  logic [bw_spec-1:0] SpecIn,
  output logic               Busy_SW,
  output logic               WrEn,
  output logic [bw_bin-1:0]  WrAddr,
  output logic [bw_spec-1:0] WrData,
  output logic [bw_bin-1:0]  RdAddr,
  input  logic [bw_spec-1:0] RdData,
  output logic               FrameDone
);

  localparam logic [bw_bin-1:0]  LAST_BIN = bw_bin'(NUM_BINS - 1);
  localparam logic [bw_spec:0]   DECAY_W  = (bw_spec + 1)'(DECAY);

  typedef enum logic [2:0] {IDLE, LOAD, READ, MERGE, WRITE, DONE} state_t;

  state_t             state;
  logic [bw_bin-1:0]  bin_cnt;
  logic [bw_bin-1:0]  r_addr;
  logic [bw_spec-1:0] r_val;
  logic [bw_spec-1:0] r_last;
  // Set when obstart lands while an operation is in flight, so its DONE must not advance.
  logic               restart;

`ifdef PEAK_HOLD_EN
  logic [bw_spec:0]   rd_ext;
  logic [bw_spec-1:0] decayed;
  logic [bw_spec-1:0] merged;

  always_comb begin
    rd_ext  = {1'b0, RdData};
    decayed = '0;
    if (rd_ext >= DECAY_W)
      decayed = bw_spec'(rd_ext - DECAY_W);
    merged  = (decayed > r_val) ? decayed : r_val;
  end
`else
  logic rd_unused;
  assign rd_unused = ^{RdData, DECAY_W};
  assign RdAddr    = '0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      r_addr    <= '0;
      r_val     <= '0;
      r_last    <= '0;
      restart   <= 1'b0;
      Busy_SW   <= 1'b0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      FrameDone <= 1'b0;
`ifdef PEAK_HOLD_EN
      RdAddr    <= '0;
`endif
    end else begin
      FrameDone <= 1'b0;
      if (obstart) begin
        bin_cnt <= '0;
        r_last  <= '0;
        if (state != IDLE)
          restart <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (Start_SW) begin
            // A coincident obstart clears the counter and last value before they are used.
            r_val   <= Copy ? (obstart ? '0 : r_last) : SpecIn;
            r_addr  <= obstart ? '0 : bin_cnt;
            Busy_SW <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
`ifdef PEAK_HOLD_EN
          RdAddr <= r_addr;
          state  <= READ;
`else
          WrEn   <= 1'b1;
          WrAddr <= r_addr;
          WrData <= r_val;
          state  <= WRITE;
`endif
        end
`ifdef PEAK_HOLD_EN
        READ: state <= MERGE;
        MERGE: begin
          r_val  <= merged;
          WrEn   <= 1'b1;
          WrAddr <= r_addr;
          WrData <= merged;
          state  <= WRITE;
        end
`endif
        WRITE: begin
          WrEn  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          Busy_SW <= 1'b0;
          restart <= 1'b0;
          state   <= IDLE;
          if (!obstart && !restart) begin
            r_last <= r_val;
            if (bin_cnt == LAST_BIN) begin
              bin_cnt   <= '0;
              FrameDone <= 1'b1;
            end else begin
              bin_cnt <= bin_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
